// File: rtl/seg_scan_mux.sv
// Four-digit seven-segment scan multiplexer for a common-anode display.
// The slow divider clock is synchronised and edge-detected into a scan tick;
// each tick advances one digit. Displayed value and decimal points change
// only at frame boundaries so a frame never mixes old and new digits.
module seg_scan_mux #(
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        div_clock,
    input  logic [15:0] value,
    input  logic        load,
    input  logic [3:0]  dp,
    output logic [3:0]  anode,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic [1:0]  digit_idx
);

    logic        s1_q, s2_q, s3_q;
    logic        tick;
    logic        frame_end;
    logic [1:0]  idx_q;
    logic [15:0] pending_q, shown_q;
    logic [3:0]  pending_dp_q, shown_dp_q;
    logic [3:0]  anode_q, anode_d;
    logic [6:0]  seg_q, seg_d;
    logic        dp_n_q, dp_n_d;
    logic [3:0]  nibble;
    logic        upper_zero;
    logic        blank;

    assign tick      = s2_q & ~s3_q;
    assign frame_end = tick && (idx_q == 2'd3);

    // Two-flop synchroniser plus previous-sample flop for rising-edge detect.
    always_ff @(posedge clock) begin
        if (!reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= div_clock;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // Scan counter advances once per tick and wraps naturally at 4.
    always_ff @(posedge clock) begin
        if (!reset) begin
            idx_q <= 2'd0;
        end else if (tick) begin
            idx_q <= idx_q + 2'd1;
        end
    end

    // Staging and display registers; a load on the boundary tick bypasses staging.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pending_q    <= 16'h0000;
            pending_dp_q <= 4'h0;
            shown_q      <= 16'h0000;
            shown_dp_q   <= 4'h0;
        end else begin
            if (load) begin
                pending_q    <= value;
                pending_dp_q <= dp;
            end
            if (frame_end) begin
                shown_q    <= load ? value : pending_q;
                shown_dp_q <= load ? dp : pending_dp_q;
            end
        end
    end

    // Select current nibble, decide blanking, and decode to active-low segments.
    always_comb begin
        nibble     = 4'h0;
        upper_zero = 1'b0;
        unique case (idx_q)
            2'd0: begin
                nibble     = shown_q[3:0];
                upper_zero = 1'b0;
            end
            2'd1: begin
                nibble     = shown_q[7:4];
                upper_zero = (shown_q[15:4] == 12'h000);
            end
            2'd2: begin
                nibble     = shown_q[11:8];
                upper_zero = (shown_q[15:8] == 8'h00);
            end
            2'd3: begin
                nibble     = shown_q[15:12];
                upper_zero = (shown_q[15:12] == 4'h0);
            end
        endcase

        blank = BLANK_LEADING && upper_zero && !shown_dp_q[idx_q];

        case (nibble)
            4'h0: seg_d = 7'b1000000;
            4'h1: seg_d = 7'b1111001;
            4'h2: seg_d = 7'b0100100;
            4'h3: seg_d = 7'b0110000;
            4'h4: seg_d = 7'b0011001;
            4'h5: seg_d = 7'b0010010;
            4'h6: seg_d = 7'b0000010;
            4'h7: seg_d = 7'b1111000;
            4'h8: seg_d = 7'b0000000;
            4'h9: seg_d = 7'b0010000;
            4'hA: seg_d = 7'b0001000;
            4'hB: seg_d = 7'b0000011;
            4'hC: seg_d = 7'b1000110;
            4'hD: seg_d = 7'b0100001;
            4'hE: seg_d = 7'b0000110;
            default: seg_d = 7'b0001110;
        endcase
        anode_d = ~(4'b0001 << idx_q);
        dp_n_d  = ~shown_dp_q[idx_q];

        if (blank) begin
            anode_d = 4'b1111;
            seg_d   = 7'b1111111;
            dp_n_d  = 1'b1;
        end
    end

    // Output registers: all segments and anodes off during reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            anode_q <= 4'b1111;
            seg_q   <= 7'b1111111;
            dp_n_q  <= 1'b1;
        end else begin
            anode_q <= anode_d;
            seg_q   <= seg_d;
            dp_n_q  <= dp_n_d;
        end
    end

    assign anode     = anode_q;
    assign seg       = seg_q;
    assign dp_n      = dp_n_q;
    assign digit_idx = idx_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux: one instance without blanking, one with.
module tb_seg_scan_mux;

    logic        clock;
    logic        reset;
    logic        div_clock;
    logic [15:0] value;
    logic        load;
    logic [3:0]  dp;

    logic [3:0]  anode0, anode1;
    logic [6:0]  seg0, seg1;
    logic        dp_n0, dp_n1;
    logic [1:0]  idx0, idx1;

    int checks = 0;
    int failures = 0;

    localparam logic [6:0] SegOff = 7'b1111111;
    localparam logic [6:0] Seg0 = 7'b1000000;
    localparam logic [6:0] Seg1 = 7'b1111001;
    localparam logic [6:0] Seg2 = 7'b0100100;
    localparam logic [6:0] Seg3 = 7'b0110000;
    localparam logic [6:0] Seg4 = 7'b0011001;
    localparam logic [6:0] Seg5 = 7'b0010010;
    localparam logic [6:0] SegA = 7'b0001000;
    localparam logic [6:0] SegB = 7'b0000011;
    localparam logic [6:0] SegC = 7'b1000110;
    localparam logic [6:0] SegD = 7'b0100001;
    localparam logic [6:0] SegF = 7'b0001110;

    seg_scan_mux #(.BLANK_LEADING(1'b0)) u_dut0 (
        .clock     (clock),
        .reset     (reset),
        .div_clock (div_clock),
        .value     (value),
        .load      (load),
        .dp        (dp),
        .anode     (anode0),
        .seg       (seg0),
        .dp_n      (dp_n0),
        .digit_idx (idx0)
    );

    seg_scan_mux #(.BLANK_LEADING(1'b1)) u_dut1 (
        .clock     (clock),
        .reset     (reset),
        .div_clock (div_clock),
        .value     (value),
        .load      (load),
        .dp        (dp),
        .anode     (anode1),
        .seg       (seg1),
        .dp_n      (dp_n1),
        .digit_idx (idx1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One div_clock pulse (5 cycles high, 5 low). Checks the no-blank instance:
    // digit_idx changes at the third edge, anode/seg at the fourth.
    task automatic pulse(input logic [1:0] exp_idx, input logic [6:0] exp_seg,
                         input logic do_load, input logic [15:0] ld_val,
                         input logic [3:0] ld_dp);
        logic [3:0] old_anode;
        logic [3:0] new_anode;
        old_anode = anode0;
        new_anode = ~(4'b0001 << exp_idx);
        div_clock = 1'b1;
        step();
        step();
        if (do_load) begin
            load  = 1'b1;
            value = ld_val;
            dp    = ld_dp;
        end
        step();
        load = 1'b0;
        check("idx_after_e2", {14'd0, idx0}, {14'd0, exp_idx});
        check("anode_held_e2", {12'd0, anode0}, {12'd0, old_anode});
        step();
        check("anode_after_e3", {12'd0, anode0}, {12'd0, new_anode});
        check("seg_after_e3", {9'd0, seg0}, {9'd0, exp_seg});
        step();
        div_clock = 1'b0;
        repeat (5) step();
        check("one_tick_per_pulse", {14'd0, idx0}, {14'd0, exp_idx});
    endtask

    task automatic load_now(input logic [15:0] v, input logic [3:0] d);
        load  = 1'b1;
        value = v;
        dp    = d;
        step();
        load = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        div_clock = 1'b0;
        value     = 16'h0000;
        load      = 1'b0;
        dp        = 4'h0;

        // Reset held 3 cycles: display dark.
        repeat (3) begin
            step();
            check("rst_anode", {12'd0, anode0}, 16'h000F);
            check("rst_seg", {9'd0, seg0}, {9'd0, SegOff});
        end
        reset = 1'b1;
        step();
        check("post_rst_anode", {12'd0, anode0}, 16'h000E);
        check("post_rst_seg", {9'd0, seg0}, {9'd0, Seg0});
        check("post_rst_idx", {14'd0, idx0}, 16'h0000);
        check("post_rst_dp_n", {15'd0, dp_n0}, 16'h0001);

        // Scan order on an all-zero value.
        pulse(2'd1, Seg0, 1'b0, 16'h0, 4'h0);
        pulse(2'd2, Seg0, 1'b0, 16'h0, 4'h0);
        pulse(2'd3, Seg0, 1'b0, 16'h0, 4'h0);
        pulse(2'd0, Seg0, 1'b0, 16'h0, 4'h0);

        // Frame coherence: load mid-frame at digit 1.
        pulse(2'd1, Seg0, 1'b0, 16'h0, 4'h0);
        load_now(16'h1234, 4'h0);
        pulse(2'd2, Seg0, 1'b0, 16'h0, 4'h0);
        pulse(2'd3, Seg0, 1'b0, 16'h0, 4'h0);
        pulse(2'd0, Seg4, 1'b0, 16'h0, 4'h0);
        pulse(2'd1, Seg3, 1'b0, 16'h0, 4'h0);
        pulse(2'd2, Seg2, 1'b0, 16'h0, 4'h0);
        pulse(2'd3, Seg1, 1'b0, 16'h0, 4'h0);

        // Load coincident with the boundary tick bypasses staging (which holds 1234).
        pulse(2'd0, SegD, 1'b1, 16'hABCD, 4'h0);
        pulse(2'd1, SegC, 1'b0, 16'h0, 4'h0);
        pulse(2'd2, SegB, 1'b0, 16'h0, 4'h0);
        pulse(2'd3, SegA, 1'b0, 16'h0, 4'h0);

        // Leading-zero blanking on the second instance.
        load_now(16'h0005, 4'b0000);
        pulse(2'd0, Seg5, 1'b0, 16'h0, 4'h0);
        check("blank_d0_seg", {9'd0, seg1}, {9'd0, Seg5});
        check("blank_d0_anode", {12'd0, anode1}, 16'h000E);
        pulse(2'd1, Seg0, 1'b0, 16'h0, 4'h0);
        check("blank_d1_anode", {12'd0, anode1}, 16'h000F);
        check("blank_d1_seg", {9'd0, seg1}, {9'd0, SegOff});
        pulse(2'd2, Seg0, 1'b0, 16'h0, 4'h0);
        check("blank_d2_anode", {12'd0, anode1}, 16'h000F);
        pulse(2'd3, Seg0, 1'b0, 16'h0, 4'h0);
        check("blank_d3_anode", {12'd0, anode1}, 16'h000F);

        // A decimal point on digit 2 keeps it lit.
        load_now(16'h0005, 4'b0100);
        pulse(2'd0, Seg5, 1'b0, 16'h0, 4'h0);
        pulse(2'd1, Seg0, 1'b0, 16'h0, 4'h0);
        check("dp_d1_still_blank", {12'd0, anode1}, 16'h000F);
        pulse(2'd2, Seg0, 1'b0, 16'h0, 4'h0);
        check("dp_d2_anode", {12'd0, anode1}, 16'h000B);
        check("dp_d2_seg", {9'd0, seg1}, {9'd0, Seg0});
        check("dp_d2_dp_n", {15'd0, dp_n1}, 16'h0000);
        pulse(2'd3, Seg0, 1'b0, 16'h0, 4'h0);
        check("dp_d3_blank", {12'd0, anode1}, 16'h000F);

        // Mid-frame reset with FFFF shown at digit 2.
        load_now(16'hFFFF, 4'b0000);
        pulse(2'd0, SegF, 1'b0, 16'h0, 4'h0);
        pulse(2'd1, SegF, 1'b0, 16'h0, 4'h0);
        pulse(2'd2, SegF, 1'b0, 16'h0, 4'h0);
        reset = 1'b0;
        step();
        check("midrst_idx", {14'd0, idx0}, 16'h0000);
        check("midrst_anode", {12'd0, anode0}, 16'h000F);
        check("midrst_seg", {9'd0, seg0}, {9'd0, SegOff});
        check("midrst_dp_n", {15'd0, dp_n0}, 16'h0001);
        reset = 1'b1;
        step();
        check("midrst_rel_anode", {12'd0, anode0}, 16'h000E);
        check("midrst_rel_seg", {9'd0, seg0}, {9'd0, Seg0});
        // Staging was cleared too: the next frame still shows zero.
        pulse(2'd1, Seg0, 1'b0, 16'h0, 4'h0);
        pulse(2'd2, Seg0, 1'b0, 16'h0, 4'h0);
        pulse(2'd3, Seg0, 1'b0, 16'h0, 4'h0);
        pulse(2'd0, Seg0, 1'b0, 16'h0, 4'h0);
        check("midrst_blank_d0", {9'd0, seg1}, {9'd0, Seg0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
